// File: rtl/bus_arb_pkg.sv
// Shared types and the round-robin pick used by the host arbiter and the bus crossbar.
package bus_arb_pkg;

    typedef enum logic {ArbIdle, ArbLocked} arb_state_e;

    localparam int unsigned MaxHosts = 8;

    // First set request at index >= ptr, wrapping modulo n; returns ptr when nothing is set.
    function automatic logic [2:0] rr_select(input logic [MaxHosts-1:0] req,
                                             input logic [2:0] ptr,
                                             input int unsigned n);
        logic [2:0] sel;
        logic found;
        int unsigned idx;
        sel = ptr;
        found = 1'b0;
        idx = 0;
        for (int unsigned i = 0; i < MaxHosts; i++) begin
            if (!found && i < n) begin
                idx = (32'(ptr) + i) % n;
                if (req[idx[2:0]]) begin
                    sel = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Small ID FIFO recording which host owns each outstanding transaction.
module bus_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    // Explicit compare-and-wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign head_o  = mem[rptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            if (do_push && !do_pop)      count <= count + CntW'(1);
            else if (do_pop && !do_push) count <= count - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between several hosts,
// routing each response back to its issuer through an ID FIFO.
module bus_host_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NrHosts-1:0]                     host_req_i,
    output logic [NrHosts-1:0]                     host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                     host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                     host_rvalid_o,
    output logic [DataWidth-1:0]                   host_rdata_o,
    output logic [NrHosts-1:0]                     host_err_o,
    output logic                                   dev_req_o,
    input  logic                                   dev_gnt_i,
    output logic [AddressWidth-1:0]                dev_addr_o,
    output logic                                   dev_we_o,
    output logic [DataWidth/8-1:0]                 dev_be_o,
    output logic [DataWidth-1:0]                   dev_wdata_o,
    input  logic                                   dev_rvalid_i,
    input  logic [DataWidth-1:0]                   dev_rdata_i,
    input  logic                                   dev_err_i,
    output logic                                   unexpected_rsp_o
);
    import bus_arb_pkg::*;

    localparam int unsigned IdW = $clog2(NrHosts);

    arb_state_e     state;
    arb_state_e     state_next;
    logic [IdW-1:0] rr_ptr;
    logic [IdW-1:0] lock_id;
    logic [IdW-1:0] cand;
    logic [IdW-1:0] sel;
    logic [IdW-1:0] head;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    assign cand = IdW'(rr_select(MaxHosts'(host_req_i), 3'(rr_ptr), NrHosts));

    // Outputs are gated by rst_i so everything reads zero as soon as reset asserts.
    always_comb begin
        state_next = state;
        sel        = lock_id;
        dev_req_o  = 1'b0;
        push       = 1'b0;
        host_gnt_o = '0;
        if (!rst_i) begin
            case (state)
                ArbIdle: begin
                    if (!full && |host_req_i) begin
                        sel       = cand;
                        dev_req_o = 1'b1;
                        if (dev_gnt_i) push = 1'b1;
                        else           state_next = ArbLocked;
                    end
                end
                ArbLocked: begin
                    if (!full) begin
                        if (host_req_i[lock_id]) begin
                            dev_req_o = 1'b1;
                            if (dev_gnt_i) begin
                                push       = 1'b1;
                                state_next = ArbIdle;
                            end
                        end else begin
                            state_next = ArbIdle;
                        end
                    end
                end
                default: state_next = ArbIdle;
            endcase
        end
        if (push) host_gnt_o[sel] = 1'b1;
    end

    assign dev_addr_o  = host_addr_i[sel];
    assign dev_we_o    = host_we_i[sel];
    assign dev_be_o    = host_be_i[sel];
    assign dev_wdata_o = host_wdata_i[sel];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ArbIdle;
            rr_ptr           <= '0;
            lock_id          <= '0;
            unexpected_rsp_o <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ArbIdle && state_next == ArbLocked) lock_id <= sel;
            if (push) rr_ptr <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
            if (dev_rvalid_i && empty) unexpected_rsp_o <= 1'b1;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sel),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign pop          = dev_rvalid_i && !empty && !rst_i;
    assign host_rdata_o = dev_rdata_i;

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = dev_err_i;
        end
    end

    logic [AddressWidth+DataWidth/8+DataWidth:0] lock_attr;
    assign lock_attr = {host_addr_i[lock_id], host_we_i[lock_id],
                        host_be_i[lock_id], host_wdata_i[lock_id]};

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(host_gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(host_rvalid_o));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
    a_lock_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == ArbLocked) |-> host_req_i[lock_id]);
    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == ArbLocked) |=> (state != ArbLocked) || $stable(lock_attr));

endmodule
